// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline: stage 1 registers the request, stage 2 the result.
// Define ALU_PIPE_FLAGS_EN to add registered out_zero/out_neg flags in stage 2.
module alu_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry
`ifdef ALU_PIPE_FLAGS_EN
    ,
    output logic             out_zero,
    output logic             out_neg
`endif
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_XNOR = 3'd3;
    localparam logic [2:0] OP_ADD  = 3'd4;
    localparam logic [2:0] OP_SUB  = 3'd5;
    localparam logic [2:0] OP_SHL  = 3'd6;
    localparam logic [2:0] OP_SHR  = 3'd7;

    logic             s1_valid, s2_valid;
    logic             s1_adv, s2_adv;
    logic [2:0]       s1_op;
    logic [WIDTH-1:0] s1_a, s1_b;
    logic [WIDTH-1:0] alu_result;
    logic             alu_carry;
    logic [WIDTH:0]   sum, diff;
    logic [SHW-1:0]   shamt;

    // Handshake: a transfer happens on a rising edge where valid & ready are both 1.
    // A stage advances when it is empty or the stage after it is advancing, so
    // in_ready depends only on pipeline state and out_ready, never on in_valid.
    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid;

    always_comb begin
        sum        = {1'b0, s1_a} + {1'b0, s1_b};
        diff       = {1'b0, s1_a} - {1'b0, s1_b};
        shamt      = s1_b[SHW-1:0];
        alu_result = '0;
        alu_carry  = 1'b0;
        case (s1_op)
            OP_AND:  alu_result = s1_a & s1_b;
            OP_OR:   alu_result = s1_a | s1_b;
            OP_XOR:  alu_result = s1_a ^ s1_b;
            OP_XNOR: alu_result = ~(s1_a ^ s1_b);
            OP_ADD: begin
                alu_result = sum[WIDTH-1:0];
                alu_carry  = sum[WIDTH];
            end
            // Bit WIDTH of the extended difference is set exactly when a < b.
            OP_SUB: begin
                alu_result = diff[WIDTH-1:0];
                alu_carry  = diff[WIDTH];
            end
            OP_SHL:  alu_result = s1_a << shamt;
            OP_SHR:  alu_result = s1_a >> shamt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            s1_op    <= in_op;
            s1_a     <= in_a;
            s1_b     <= in_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid   <= 1'b0;
            out_result <= '0;
            out_carry  <= 1'b0;
        end else if (s2_adv) begin
            s2_valid   <= s1_valid;
            out_result <= alu_result;
            out_carry  <= alu_carry;
        end
    end

`ifdef ALU_PIPE_FLAGS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            out_zero <= 1'b0;
            out_neg  <= 1'b0;
        end else if (s2_adv) begin
            out_zero <= (alu_result == '0);
            out_neg  <= alu_result[WIDTH-1];
        end
    end
`endif

endmodule
